pulse_train_gen: RTL and testbench
==================================

Name: pulse_train_gen

Overview:
- Generates key-press-style output pulses from single-cycle event strobes. It works in the opposite direction to the edge detector: it turns one-cycle strobes back into held levels.
- Each accepted event produces an output high for HOLD_CYCLES clocks, followed by a mandatory low gap of GAP_CYCLES clocks.
- Events that arrive while a pulse is in progress are queued in a saturating pending counter.
- Used to drive dispense solenoids and indicator outputs from controller strobes.

Parameters:
- HOLD_CYCLES, 4, output high duration in clocks; must be >= 1.
- GAP_CYCLES, 2, minimum low time after each pulse; 0 means no gap.
- PEND_W, 2, width of the pending counter; maximum queued events = 2^PEND_W - 1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- ev_in  input  1  event strobe; each high cycle is one event.
- clr_ovf  input  1  synchronous clear of the overflow flag.
- pulse_out  output  1  generated pulse, registered.
- busy  output  1  high when state is not IDLE, registered.
- pending  output  PEND_W  number of queued events.
- overflow  output  1  sticky flag: an event was dropped.
- done  output  1  one-cycle strobe in the final cycle of each pulse/gap sequence.

Behaviour:
- Reset (reset low, asynchronous):
  - state = IDLE.
  - pulse_out = busy = done = overflow = 0; pending = 0; timer = 0.
  - Asserting reset mid-pulse drops pulse_out immediately and discards the queue.
- FSM states: IDLE, HIGH, GAP. The timer is $clog2(max(HOLD_CYCLES, GAP_CYCLES, 2)) bits wide.
- IDLE:
  - ev_in = 1 at edge k moves to HIGH; pulse_out = 1 from cycle k+1. Latency is exactly 1 clock.
  - The event is consumed directly and pending is unchanged.
- HIGH:
  - pulse_out = 1 for exactly HOLD_CYCLES cycles.
  - Then move to GAP, or, if GAP_CYCLES = 0, apply the end-of-sequence rule directly.
- GAP:
  - pulse_out = 0 for exactly GAP_CYCLES cycles.
  - done = 1 during the last GAP cycle. If GAP_CYCLES = 0, done is high during the last HIGH cycle.
- End of sequence:
  - If pending > 0 or ev_in = 1 in that cycle, go to HIGH and consume one event. This gives back-to-back pulses with no extra idle cycle.
  - Otherwise go to IDLE.
- ev_in while busy:
  - Not at end of sequence: pending increments.
  - At end of sequence with pending > 0: the arriving event and the consumed event cancel, so pending is unchanged.
  - At end of sequence with pending = 0: the arriving event is consumed directly, so pending stays 0.
- Saturation:
  - If pending = 2^PEND_W - 1 and an increment is required, pending holds and overflow is set from the next cycle.
  - overflow stays set until clr_ovf.
  - If set and clr_ovf occur in the same cycle, set wins.
- The pending counter never wraps; underflow is impossible by construction.
- All outputs are driven from flops; there is no combinational path from ev_in to any output.

Optional Feature:
- Macro: PULSE_TRAIN_GEN_RETRIG_EN.
- Defined:
  - ev_in during HIGH restarts the hold timer, so pulse_out stays high for HOLD_CYCLES counted from the cycle after the latest event.
  - That event is not queued and pending is unchanged.
  - ev_in during GAP still queues.
- Undefined: ev_in during HIGH queues as described above. The retrigger logic is absent.

Test Plan:
- Defaults; reset released; ev_in at cycle 0 -> pulse_out high cycles 1-4, low 5-6; done=1 at cycle 6 only; busy=1 cycles 1-6; pending=0 throughout.
- ev_in at cycles 0 and 2 -> pending=1 during cycles 3-6; pulse_out high 1-4 and 7-10; pending=0 from cycle 7; done at cycles 6 and 12.
- ev_in at cycles 0-4 inclusive -> pending reaches 3 at cycle 4; the event at cycle 4 is dropped; overflow=1 from cycle 5; clr_ovf at cycle 8 -> overflow=0 at cycle 9; exactly 4 pulses emitted.
- ev_in at cycle 0 and at cycle 6 (the done cycle) -> second pulse high cycles 7-10 with no idle gap; pending stays 0.
- Reset driven low at cycle 2 of a pulse -> pulse_out, busy and pending go to 0 without waiting for a clock edge; ev_in at the first cycle after release -> normal pulse 1 cycle later.
- PULSE_TRAIN_GEN_RETRIG_EN defined; ev_in at cycles 0 and 2 -> pulse_out high cycles 1-6, low 7-8; done at cycle 8; pending=0.

Source files
------------

// File: rtl/pulse_train_gen.sv
// Turns single-cycle event strobes into held pulses (HOLD_CYCLES high, GAP_CYCLES low),
// queueing extra events in a saturating counter. Optional macro: PULSE_TRAIN_GEN_RETRIG_EN.
module pulse_train_gen #(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 2,
  parameter int PEND_W      = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ev_in,
  input  logic              clr_ovf,
  output logic              pulse_out,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow,
  output logic              done
);

  localparam int MAX_HG = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int TMAX   = (MAX_HG > 2) ? MAX_HG : 2;
  localparam int TW     = $clog2(TMAX);
  localparam bit NO_GAP = (GAP_CYCLES == 0);
  localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LAST  = TW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};

  typedef enum logic [1:0] {IDLE, HIGH, GAP} state_t;

  state_t            state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              ovf_q, ovf_d;
  logic              pulse_q, busy_q, done_q, done_d;
  logic              finish, queueEv, drop;

  // The timer counts down the cycles left in the current phase; zero marks its last cycle.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    pend_d  = pend_q;
    finish  = 1'b0;
    queueEv = 1'b0;
    drop    = 1'b0;

    case (state_q)
      IDLE: begin
        if (ev_in) begin
          state_d = HIGH;
          timer_d = HOLD_LAST;
        end
      end
      HIGH: begin
`ifdef PULSE_TRAIN_GEN_RETRIG_EN
        if (ev_in) begin
          timer_d = HOLD_LAST;
        end else
`endif
        if (timer_q != '0) begin
          timer_d = timer_q - TW'(1);
          queueEv = 1'b1;
        end else if (NO_GAP) begin
          finish = 1'b1;
        end else begin
          state_d = GAP;
          timer_d = GAP_LAST;
          queueEv = 1'b1;
        end
      end
      GAP: begin
        if (timer_q != '0) begin
          timer_d = timer_q - TW'(1);
          queueEv = 1'b1;
        end else begin
          finish = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase

    // An event arriving in the final cycle cancels against the one being consumed.
    if (finish) begin
      if (pend_q != '0) begin
        state_d = HIGH;
        timer_d = HOLD_LAST;
        if (!ev_in) begin
          pend_d = pend_q - PEND_W'(1);
        end
      end else if (ev_in) begin
        state_d = HIGH;
        timer_d = HOLD_LAST;
      end else begin
        state_d = IDLE;
        timer_d = '0;
      end
    end

    if (queueEv && ev_in) begin
      if (pend_q == PEND_MAX) begin
        drop = 1'b1;
      end else begin
        pend_d = pend_q + PEND_W'(1);
      end
    end

    ovf_d = ovf_q;
    if (clr_ovf) begin
      ovf_d = 1'b0;
    end
    if (drop) begin
      ovf_d = 1'b1;
    end

    done_d = ((state_d == GAP) && (timer_d == '0)) ||
             (NO_GAP && (state_d == HIGH) && (timer_d == '0));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      timer_q <= '0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      pulse_q <= (state_d == HIGH);
      busy_q  <= (state_d != IDLE);
      done_q  <= done_d;
    end
  end

  assign pulse_out = pulse_q;
  assign busy      = busy_q;
  assign pending   = pend_q;
  assign overflow  = ovf_q;
  assign done      = done_q;

endmodule

// File: tb/tb_pulse_train_gen.sv
// Testbench for pulse_train_gen: directed scenarios plus random strobes, checked each
// cycle against a sequence-position model of the pulse/gap/queue rules.
module tb_pulse_train_gen;

  localparam int HOLD = 4;
  localparam int GAP  = 2;
  localparam int PW   = 2;
  localparam int SEQ  = HOLD + GAP;
  localparam int PMAX = (1 << PW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          ev_in;
  logic          clr_ovf;
  logic          pulse_out;
  logic          busy;
  logic [PW-1:0] pending;
  logic          overflow;
  logic          done;

  int checks    = 0;
  int passCount = 0;
  int mPos      = 0;
  int mPend     = 0;
  bit mOvf      = 1'b0;
  int riseCount = 0;
  logic prevPulse = 1'b0;

  always #5 clk = ~clk;

  pulse_train_gen #(
    .HOLD_CYCLES(HOLD),
    .GAP_CYCLES (GAP),
    .PEND_W     (PW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .ev_in    (ev_in),
    .clr_ovf  (clr_ovf),
    .pulse_out(pulse_out),
    .busy     (busy),
    .pending  (pending),
    .overflow (overflow),
    .done     (done)
  );

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks += 1;
    assert (obs === exp) passCount += 1;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // mPos is the 1-based cycle index inside the current pulse+gap sequence; 0 means idle.
  task automatic modelStep(input logic ev, input logic clr);
    bit dropped = 1'b0;
    if (mPos == 0) begin
      if (ev) mPos = 1;
    end else if (mPos == SEQ) begin
      if (mPend > 0) begin
        mPos = 1;
        if (!ev) mPend = mPend - 1;
      end else if (ev) begin
        mPos = 1;
      end else begin
        mPos = 0;
      end
    end else begin
`ifdef PULSE_TRAIN_GEN_RETRIG_EN
      if (ev && mPos <= HOLD) begin
        mPos = 1;
      end else
`endif
      begin
        mPos = mPos + 1;
        if (ev) begin
          if (mPend == PMAX) dropped = 1'b1;
          else mPend = mPend + 1;
        end
      end
    end
    if (clr) mOvf = 1'b0;
    if (dropped) mOvf = 1'b1;
  endtask

  task automatic modelReset();
    mPos  = 0;
    mPend = 0;
    mOvf  = 1'b0;
  endtask

  task automatic checkOutput();
    checkValue("pulse_out", 32'(pulse_out), 32'(mPos >= 1 && mPos <= HOLD));
    checkValue("busy",      32'(busy),      32'(mPos != 0));
    checkValue("done",      32'(done),      32'(mPos == SEQ));
    checkValue("pending",   32'(pending),   32'(mPend));
    checkValue("overflow",  32'(overflow),  32'(mOvf));
    if (pulse_out && !prevPulse) riseCount += 1;
    prevPulse = pulse_out;
  endtask

  task automatic applyStimulus(input logic ev, input logic clr);
    @(negedge clk);
    ev_in   = ev;
    clr_ovf = clr;
    @(posedge clk);
    modelStep(ev, clr);
    #1 checkOutput();
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0);
  endtask

  initial begin
    reset   = 1'b0;
    ev_in   = 1'b0;
    clr_ovf = 1'b0;
    #2;
    checkOutput();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    idleCycles(2);

    $display("[TB] single event");
    applyStimulus(1'b1, 1'b0);
    idleCycles(8);

    $display("[TB] event queued during pulse");
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    idleCycles(12);

    $display("[TB] overflow and clear");
    riseCount = 0;
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0);
    idleCycles(3);
    applyStimulus(1'b0, 1'b1);
    idleCycles(22);
    checkValue("pulse_count", 32'(riseCount), 32'd4);

    $display("[TB] event in done cycle");
    applyStimulus(1'b1, 1'b0);
    idleCycles(5);
    applyStimulus(1'b1, 1'b0);
    idleCycles(8);

    $display("[TB] async reset mid-pulse");
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    checkValue("pending_before_reset", 32'(pending), 32'd1);
    @(negedge clk);
    ev_in = 1'b0;
    reset = 1'b0;
    #1;
    modelReset();
    checkOutput();
    @(negedge clk);
    reset = 1'b1;
    ev_in = 1'b1;
    @(posedge clk);
    modelStep(1'b1, 1'b0);
    #1 checkOutput();
    checkValue("pulse_after_release", 32'(pulse_out), 32'd1);
    idleCycles(8);

    $display("[TB] random strobes");
    for (int i = 0; i < 400; i++) begin
      applyStimulus(logic'($urandom_range(0, 99) < 45), logic'($urandom_range(0, 99) < 4));
    end
    idleCycles(40);

    $display("%0d/%0d checks passed", passCount, checks);
    $finish;
  end

endmodule
